lcd_rom_driver: RTL and testbench

- Reader/consumer end of the 32-character screen-ROM interface (5-bit `raddr` out, 8-bit `dout` in).
- Initialises an HD44780-compatible 16x2 character LCD in 8-bit write-only mode.
- Continuously scans ROM addresses 0x00-0x1F and writes them to the panel.
- 0x00-0x0F go to line 1 (DDRAM 0x00); 0x10-0x1F go to line 2 (DDRAM 0x40).

---
 rtl/lcd_rom_driver_if.sv | 30 +++
 rtl/lcd_rom_driver.sv | 192 +++++++++++++++++++
 tb/tb_lcd_rom_driver.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_rom_driver_if.sv
// rtl/lcd_rom_driver_if.sv - screen-ROM read port and HD44780 bus bundle; update_req under LCD_UPDATE_REQ_EN
interface lcd_rom_driver_if;
  logic [4:0] raddr;
  logic [7:0] dout;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic       init_done;
  logic       frame_done;
`ifdef LCD_UPDATE_REQ_EN
  logic       update_req;
`endif

  modport master (
    output raddr, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done,
    input  dout
`ifdef LCD_UPDATE_REQ_EN
    , input update_req
`endif
  );

  modport slave (
    input  raddr, lcd_rs, lcd_rw, lcd_e, lcd_data, init_done, frame_done,
    output dout
`ifdef LCD_UPDATE_REQ_EN
    , output update_req
`endif
  );
endinterface

// File: rtl/lcd_rom_driver.sv
// rtl/lcd_rom_driver.sv - HD44780 16x2 init and continuous 32-char screen-ROM scan
// Optional request-driven frames when LCD_UPDATE_REQ_EN is defined.
module lcd_rom_driver #(
  parameter int POWERON_CYCLES    = 750000,
  parameter int SETUP_CYCLES      = 2,
  parameter int ENABLE_CYCLES     = 12,
  parameter int CMD_WAIT_CYCLES   = 2000,
  parameter int CLEAR_WAIT_CYCLES = 82000
) (
  input  logic               clk,
  input  logic               rst,
  lcd_rom_driver_if.master   bus
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = imax(imax(imax(POWERON_CYCLES, SETUP_CYCLES),
                                  imax(ENABLE_CYCLES, CMD_WAIT_CYCLES)), CLEAR_WAIT_CYCLES);
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t PON_LAST   = cnt_t'(POWERON_CYCLES - 1);
  localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t EN_LAST    = cnt_t'(ENABLE_CYCLES - 1);
  localparam cnt_t CMD_LAST   = cnt_t'(CMD_WAIT_CYCLES - 1);
  localparam cnt_t CLR_LAST   = cnt_t'(CLEAR_WAIT_CYCLES - 1);
  localparam cnt_t CNT_ONE    = cnt_t'(1);

  typedef enum logic [2:0] {
    S_POWERON, S_SETUP, S_EHIGH, S_WAIT, S_FETCH, S_CAPTURE, S_IDLE
  } state_t;

  // What the current bus transaction was, so the end of its wait knows where to go.
  typedef enum logic [1:0] {K_INIT, K_LINE, K_CHAR} kind_t;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: return 8'h38;
      3'd2:       return 8'h0C;
      3'd3:       return 8'h06;
      default:    return 8'h01;
    endcase
  endfunction

  state_t     r_state;
  kind_t      r_kind;
  cnt_t       r_cnt;
  logic [2:0] r_init_idx;
  logic [4:0] r_raddr;
  logic       r_rs;
  logic       r_e;
  logic [7:0] r_data;
  logic       r_init_done;
  logic       r_frame_done;
`ifdef LCD_UPDATE_REQ_EN
  logic       r_pending;
`endif

  cnt_t w_wait_last;
  assign w_wait_last = (!r_rs && r_data == 8'h01) ? CLR_LAST : CMD_LAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_POWERON;
      r_kind       <= K_INIT;
      r_cnt        <= '0;
      r_init_idx   <= '0;
      r_raddr      <= '0;
      r_rs         <= 1'b0;
      r_e          <= 1'b0;
      r_data       <= '0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef LCD_UPDATE_REQ_EN
      r_pending    <= 1'b0;
`endif
    end else begin
      r_frame_done <= 1'b0;
`ifdef LCD_UPDATE_REQ_EN
      r_pending    <= r_pending | bus.update_req;
`endif
      case (r_state)
        S_POWERON: begin
          if (r_cnt == PON_LAST) begin
            r_cnt   <= '0;
            r_data  <= init_cmd(3'd0);
            r_rs    <= 1'b0;
            r_kind  <= K_INIT;
            r_state <= S_SETUP;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_SETUP: begin
          if (r_cnt == SETUP_LAST) begin
            r_cnt   <= '0;
            r_e     <= 1'b1;
            r_state <= S_EHIGH;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_EHIGH: begin
          if (r_cnt == EN_LAST) begin
            r_cnt   <= '0;
            r_e     <= 1'b0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_WAIT: begin
          if (r_cnt == w_wait_last) begin
            r_cnt <= '0;
            case (r_kind)
              K_INIT: begin
                if (r_init_idx == 3'd4) begin
                  r_init_done <= 1'b1;
`ifdef LCD_UPDATE_REQ_EN
                  r_state     <= S_IDLE;
`else
                  r_data      <= 8'h80;
                  r_kind      <= K_LINE;
                  r_state     <= S_SETUP;
`endif
                end else begin
                  r_init_idx <= r_init_idx + 3'd1;
                  r_data     <= init_cmd(r_init_idx + 3'd1);
                  r_state    <= S_SETUP;
                end
              end
              K_LINE: r_state <= S_FETCH;
              default: begin
                r_raddr <= r_raddr + 5'd1;
                if (r_raddr == 5'h1F) begin
                  r_frame_done <= 1'b1;
`ifdef LCD_UPDATE_REQ_EN
                  r_state      <= S_IDLE;
`else
                  r_data       <= 8'h80;
                  r_rs         <= 1'b0;
                  r_kind       <= K_LINE;
                  r_state      <= S_SETUP;
`endif
                end else if (r_raddr == 5'h0F) begin
                  r_data  <= 8'hC0;
                  r_rs    <= 1'b0;
                  r_kind  <= K_LINE;
                  r_state <= S_SETUP;
                end else begin
                  r_state <= S_FETCH;
                end
              end
            endcase
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_FETCH: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_data  <= bus.dout;
          r_rs    <= 1'b1;
          r_kind  <= K_CHAR;
          r_state <= S_SETUP;
        end
        S_IDLE: begin
`ifdef LCD_UPDATE_REQ_EN
          if (r_pending || bus.update_req) begin
            r_pending <= 1'b0;
            r_data    <= 8'h80;
            r_rs      <= 1'b0;
            r_kind    <= K_LINE;
            r_state   <= S_SETUP;
          end
`endif
        end
        default: r_state <= S_POWERON;
      endcase
    end
  end

  assign bus.raddr      = r_raddr;
  assign bus.lcd_rs     = r_rs;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_e      = r_e;
  assign bus.lcd_data   = r_data;
  assign bus.init_done  = r_init_done;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_lcd_rom_driver.sv
// tb/tb_lcd_rom_driver.sv - self-checking bench for lcd_rom_driver (both LCD_UPDATE_REQ_EN builds)
module tb_lcd_rom_driver;
  localparam int PON = 20;
  localparam int SET = 1;
  localparam int ENA = 2;
  localparam int CMW = 4;
  localparam int CLW = 10;
  localparam int FRAME_TR = 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_rom_driver_if bus ();

  lcd_rom_driver #(
    .POWERON_CYCLES(PON), .SETUP_CYCLES(SET), .ENABLE_CYCLES(ENA),
    .CMD_WAIT_CYCLES(CMW), .CLEAR_WAIT_CYCLES(CLW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] rom [32];
  assign bus.dout = rom[bus.raddr];

  typedef struct {
    int         rise;
    int         fall;
    logic [8:0] rd;
    int         setup;
    bit         stable;
  } tr_t;

  tr_t        tr[$];
  int         fd_q[$];
  logic [8:0] exp_q[$];
  int         idone_cyc;
  bit         idone_fell;
  int         cyc;
  int         n_checks = 0;
  int         n_fail   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Records every E pulse as one transaction, sampled on the falling clock edge.
  initial begin
    logic       prev_e, prev_idone, chg;
    logic [8:0] prev_rd, cur_rd;
    int         last_chg;
    tr_t        t;
    prev_e = 0; prev_idone = 0; prev_rd = '0; last_chg = 0;
    idone_cyc = -1; idone_fell = 0;
    t = '{0, 0, 9'h0, 0, 1'b0};
    forever begin
      @(negedge clk);
      if (rst) begin
        tr.delete(); fd_q.delete();
        prev_e = 0; prev_idone = 0; prev_rd = '0; last_chg = 0;
        idone_cyc = -1; idone_fell = 0;
      end else begin
        cur_rd = {bus.lcd_rs, bus.lcd_data};
        chg = (cur_rd != prev_rd);
        if (chg) last_chg = cyc;
        if (bus.lcd_e && !prev_e) begin
          t.rise = cyc; t.rd = cur_rd; t.setup = cyc - last_chg; t.stable = 1'b1;
        end else if (bus.lcd_e && chg) begin
          t.stable = 1'b0;
        end
        if (!bus.lcd_e && prev_e) begin
          t.fall = cyc;
          tr.push_back(t);
        end
        if (bus.frame_done) fd_q.push_back(cyc);
        if (bus.init_done && idone_cyc < 0) idone_cyc = cyc;
        if (!bus.init_done && prev_idone) idone_fell = 1'b1;
        prev_e = bus.lcd_e; prev_idone = bus.init_done; prev_rd = cur_rd;
      end
    end
  end

  function automatic void push_init();
    exp_q.delete();
    exp_q.push_back(9'h038); exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
    exp_q.push_back(9'h006); exp_q.push_back(9'h001);
  endfunction

  function automatic void push_frame();
    exp_q.push_back(9'h080);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, rom[i]});
    exp_q.push_back(9'h0C0);
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, rom[i]});
  endfunction

  function automatic int wait_of(input logic [8:0] rd);
    return (rd == 9'h001) ? CLW : CMW;
  endfunction

`ifdef LCD_UPDATE_REQ_EN
  task automatic pulse_req();
    @(negedge clk); bus.update_req = 1'b1;
    @(negedge clk); bus.update_req = 1'b0;
  endtask
`endif

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) rom[i] = 8'h41 + 8'(i);
    push_init();
    push_frame();
    repeat (2) @(negedge clk);
    n_checks += 7;
    if (bus.raddr !== 5'h00)     begin n_fail++; $display("FAIL reset_raddr: got %h, required 00", bus.raddr); end
    if (bus.lcd_rs !== 1'b0)     begin n_fail++; $display("FAIL reset_rs: got %b, required 0", bus.lcd_rs); end
    if (bus.lcd_rw !== 1'b0)     begin n_fail++; $display("FAIL reset_rw: got %b, required 0", bus.lcd_rw); end
    if (bus.lcd_e !== 1'b0)      begin n_fail++; $display("FAIL reset_e: got %b, required 0", bus.lcd_e); end
    if (bus.lcd_data !== 8'h00)  begin n_fail++; $display("FAIL reset_data: got %h, required 00", bus.lcd_data); end
    if (bus.init_done !== 1'b0)  begin n_fail++; $display("FAIL reset_init_done: got %b, required 0", bus.init_done); end
    if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, required 0", bus.frame_done); end
    rst = 1'b0;
  endtask

  task automatic test_poweron();
    int k = 0;
    while (tr.size() < 1 && k < 200) begin @(negedge clk); k++; end
    n_checks++;
    if (tr.size() < 1) begin n_fail++; $display("FAIL poweron_timeout: got no E pulse, required one"); return; end
    n_checks += 2;
    if (tr[0].rise != PON + SET) begin n_fail++; $display("FAIL poweron_first_e: got cycle %0d, required %0d", tr[0].rise, PON + SET); end
    if (tr[0].rd !== 9'h038)     begin n_fail++; $display("FAIL poweron_first_cmd: got %h, required 038", tr[0].rd); end
  endtask

  task automatic test_init();
    int k = 0;
    while ((tr.size() < 5 || idone_cyc < 0) && k < 500) begin @(negedge clk); k++; end
    n_checks++;
    if (tr.size() < 5 || idone_cyc < 0) begin n_fail++; $display("FAIL init_timeout: got %0d transactions, required 5 and init_done", tr.size()); return; end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (tr[i].rd !== exp_q[i]) begin n_fail++; $display("FAIL init_cmd%0d: got %h, required %h", i, tr[i].rd, exp_q[i]); end
    end
    n_checks += 2;
    if (idone_cyc - tr[4].fall != CLW) begin n_fail++; $display("FAIL init_clear_gap: got %0d, required %0d", idone_cyc - tr[4].fall, CLW); end
    if (bus.init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_level: got %b, required 1", bus.init_done); end
  endtask

  task automatic test_frames();
    int k = 0;
    int want;
`ifdef LCD_UPDATE_REQ_EN
    repeat (100) @(negedge clk);
    n_checks += 2;
    if (tr.size() != 5)       begin n_fail++; $display("FAIL idle_no_activity: got %0d transactions, required 5", tr.size()); end
    if (bus.raddr !== 5'h00)  begin n_fail++; $display("FAIL idle_raddr: got %h, required 00", bus.raddr); end
    pulse_req();
    while (tr.size() < 15 && k < 1000) begin @(negedge clk); k++; end
    pulse_req();
    repeat (3) @(negedge clk);
    pulse_req();
    want = 5 + 2 * FRAME_TR;
`else
    want = 5 + 2 * FRAME_TR + 1;
`endif
    k = 0;
    while (bus.frame_done !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    n_checks++;
    if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL frame1_timeout: got no frame_done, required pulse"); return; end
    for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
    push_frame();
`ifndef LCD_UPDATE_REQ_EN
    exp_q.push_back(9'h080);
`endif
    k = 0;
    while (tr.size() < want && k < 2000) begin @(negedge clk); k++; end
    repeat (200) @(negedge clk);
    n_checks += 2;
`ifdef LCD_UPDATE_REQ_EN
    if (tr.size() != want) begin n_fail++; $display("FAIL frame_count: got %0d transactions, required %0d", tr.size(), want); return; end
    if (fd_q.size() != 2)  begin n_fail++; $display("FAIL frame_done_count: got %0d, required 2", fd_q.size()); return; end
`else
    if (tr.size() < want)  begin n_fail++; $display("FAIL frame_count: got %0d transactions, required %0d", tr.size(), want); return; end
    if (fd_q.size() < 2)   begin n_fail++; $display("FAIL frame_done_count: got %0d, required 2", fd_q.size()); return; end
`endif
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (tr[i].rd !== exp_q[i]) begin n_fail++; $display("FAIL frame_write%0d: got %h, required %h", i, tr[i].rd, exp_q[i]); end
    end
    for (int f = 0; f < 2; f++) begin
      n_checks++;
      if (fd_q[f] != tr[4 + FRAME_TR * (f + 1)].fall + CMW) begin
        n_fail++; $display("FAIL frame_done_cycle%0d: got %0d, required %0d", f, fd_q[f], tr[4 + FRAME_TR * (f + 1)].fall + CMW);
      end
    end
`ifndef LCD_UPDATE_REQ_EN
    n_checks++;
    if (tr[5 + FRAME_TR].rise != fd_q[0] + SET) begin n_fail++; $display("FAIL frame2_start: got %0d, required %0d", tr[5 + FRAME_TR].rise, fd_q[0] + SET); end
`endif
  endtask

  task automatic test_timing();
    for (int i = 0; i < tr.size(); i++) begin
      int  gap, exp_gap;
      bit  after_idle;
      n_checks += 3;
      if (tr[i].fall - tr[i].rise != ENA) begin n_fail++; $display("FAIL e_width%0d: got %0d, required %0d", i, tr[i].fall - tr[i].rise, ENA); end
      if (!tr[i].stable)                  begin n_fail++; $display("FAIL bus_stable%0d: got change during E, required none", i); end
      if (tr[i].setup < SET)              begin n_fail++; $display("FAIL setup%0d: got %0d, required >= %0d", i, tr[i].setup, SET); end
      if (i > 0) begin
        gap     = tr[i].rise - tr[i-1].fall;
        exp_gap = wait_of(tr[i-1].rd) + SET + (tr[i].rd[8] ? 2 : 0);
        after_idle = 1'b0;
`ifdef LCD_UPDATE_REQ_EN
        after_idle = (tr[i].rd == 9'h080);
`endif
        n_checks++;
        if (after_idle ? (gap < exp_gap) : (gap != exp_gap)) begin
          n_fail++; $display("FAIL gap%0d: got %0d, required %0d", i, gap, exp_gap);
        end
      end
    end
    n_checks++;
    if (idone_fell) begin n_fail++; $display("FAIL init_done_sticky: got fall, required stays high"); end
  endtask

  task automatic test_async_reset();
    int k = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    while (idone_cyc < 0 && k < 500) begin @(negedge clk); k++; end
`ifdef LCD_UPDATE_REQ_EN
    pulse_req();
`endif
    k = 0;
    while (!(bus.lcd_e === 1'b1 && bus.lcd_rs === 1'b1 && bus.raddr === 5'h07) && k < 1000) begin @(negedge clk); k++; end
    n_checks++;
    if (k >= 1000) begin n_fail++; $display("FAIL areset_timeout: got no char 07 E pulse, required one"); return; end
    #1 rst = 1'b1;
    #1;
    n_checks += 3;
    if (bus.lcd_e !== 1'b0)     begin n_fail++; $display("FAIL areset_e: got %b, required 0", bus.lcd_e); end
    if (bus.raddr !== 5'h00)    begin n_fail++; $display("FAIL areset_raddr: got %h, required 00", bus.raddr); end
    if (bus.init_done !== 1'b0) begin n_fail++; $display("FAIL areset_init_done: got %b, required 0", bus.init_done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    k = 0;
    while ((tr.size() < 5 || idone_cyc < 0) && k < 500) begin @(negedge clk); k++; end
    n_checks++;
    if (tr.size() < 5 || idone_cyc < 0) begin n_fail++; $display("FAIL areset_restart_timeout: got %0d transactions, required 5", tr.size()); return; end
    n_checks += 2;
    if (tr[0].rise != PON + SET) begin n_fail++; $display("FAIL areset_first_e: got %0d, required %0d", tr[0].rise, PON + SET); end
    if (idone_cyc - tr[4].fall != CLW) begin n_fail++; $display("FAIL areset_clear_gap: got %0d, required %0d", idone_cyc - tr[4].fall, CLW); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (tr[i].rd !== exp_q[i]) begin n_fail++; $display("FAIL areset_cmd%0d: got %h, required %h", i, tr[i].rd, exp_q[i]); end
    end
  endtask

  initial begin
`ifdef LCD_UPDATE_REQ_EN
    bus.update_req = 1'b0;
`endif
    test_reset();
    test_poweron();
    test_init();
    test_frames();
    test_timing();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1, "watchdog");
  end

endmodule
